// File: rtl/frame_manager_pkg.sv
// Shared definitions for the frame-manager write-source bus.
// Every bus client imports this package for its select and field widths.
package frame_manager_pkg;
  localparam int SOURCE_SEL_ADDRW = 3;
  localparam int WRITE_ADDR_W     = 32;
endpackage

// File: rtl/ship_sprite_draw_pkg.sv
// Local types and helpers for the player-sprite write source.
package ship_sprite_draw_pkg;
  localparam int POS_W = 11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GRANT = 2'd1,
    DRAW       = 2'd2,
    DONE       = 2'd3
  } draw_state_t;

  // Pixels inside the 2x2 squares at each sprite corner are see-through.
  function automatic logic is_corner(input int c, input int r, input int w, input int h);
    return ((c < 2) || (c >= w - 2)) && ((r < 2) || (r >= h - 2));
  endfunction
endpackage

// File: rtl/sprite_pos_clamp.sv
// One axis of sprite position: register plus saturating step up/down.
module sprite_pos_clamp
  import ship_sprite_draw_pkg::*;
#(
  parameter int START   = 0,
  parameter int MAX_POS = 624,
  parameter int STEP    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic             inc,
  input  logic             dec,
  output logic [POS_W-1:0] pos
);
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [POS_W:0]   sum;

  // One spare bit keeps the sum from wrapping before the clamp compares it.
  assign sum = {1'b0, pos_reg} + (POS_W+1)'(STEP);

  always_comb begin
    pos_next = pos_reg;
    if (update && inc && !dec) begin
      if (sum > (POS_W+1)'(MAX_POS)) pos_next = POS_W'(MAX_POS);
      else                           pos_next = sum[POS_W-1:0];
    end else if (update && dec && !inc) begin
      if (pos_reg < POS_W'(STEP)) pos_next = '0;
      else                        pos_next = pos_reg - POS_W'(STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pos_reg <= POS_W'(START);
    else       pos_reg <= pos_next;
  end

  assign pos = pos_reg;
endmodule

// File: rtl/ship_sprite_draw.sv
// Joystick-driven player sprite: moves once per frame, then streams its
// pixels to the frame manager whenever this source owns the write bus.
module ship_sprite_draw
  import frame_manager_pkg::*;
  import ship_sprite_draw_pkg::*;
#(
  parameter int                SOURCE_ID   = 3,
  parameter int                COLOR_DEPTH = 9,
  parameter logic [COLOR_DEPTH-1:0] SHIP_COLOR = 9'b111111000,
  parameter int                SPRITE_W    = 16,
  parameter int                SPRITE_H    = 16,
  parameter int                SCREEN_W    = 640,
  parameter int                SCREEN_H    = 480,
  parameter int                STEP        = 4,
  parameter int                START_X     = 312,
  parameter int                START_Y     = 400
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame,
  input  logic                        Left,
  input  logic                        Right,
  input  logic                        Up,
  input  logic                        Down,
  input  logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  input  logic                        write_awaited,
  output logic                        write_active,
  output logic [WRITE_ADDR_W-1:0]     write_x_addr,
  output logic [WRITE_ADDR_W-1:0]     write_y_addr,
  output logic [COLOR_DEPTH-1:0]      write_color_data,
  output logic                        write_transparent
);
  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  draw_state_t      state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [POS_W-1:0] pos_x, pos_y;
  logic             granted, last_col, last_row;

  sprite_pos_clamp #(.START(START_X), .MAX_POS(SCREEN_W - SPRITE_W), .STEP(STEP)) u_clamp_x (
    .clk(clk), .reset(reset), .update(frame), .inc(Right), .dec(Left), .pos(pos_x)
  );

  sprite_pos_clamp #(.START(START_Y), .MAX_POS(SCREEN_H - SPRITE_H), .STEP(STEP)) u_clamp_y (
    .clk(clk), .reset(reset), .update(frame), .inc(Down), .dec(Up), .pos(pos_y)
  );

  assign granted  = (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));
  assign last_col = (col_reg == COL_W'(SPRITE_W - 1));
  assign last_row = (row_reg == ROW_W'(SPRITE_H - 1));

  // A frame pulse in any state abandons the current sprite and restarts it.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    if (frame) begin
      state_next = WAIT_GRANT;
      col_next   = '0;
      row_next   = '0;
    end else begin
      case (state_reg)
        WAIT_GRANT: if (granted) state_next = DRAW;
        DRAW: begin
          if (!granted) begin
            state_next = WAIT_GRANT;
          end else if (write_awaited) begin
            if (last_col) begin
              col_next = '0;
              if (last_row) begin
                row_next   = '0;
                state_next = DONE;
              end else begin
                row_next = row_reg + ROW_W'(1);
              end
            end else begin
              col_next = col_reg + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
    end
  end

  // Zero when idle so the manager can OR all sources together.
  always_comb begin
    write_active      = 1'b0;
    write_x_addr      = '0;
    write_y_addr      = '0;
    write_color_data  = '0;
    write_transparent = 1'b0;
    if ((state_reg == DRAW) && granted) begin
      write_active      = 1'b1;
      write_x_addr      = WRITE_ADDR_W'(pos_x) + WRITE_ADDR_W'(col_reg);
      write_y_addr      = WRITE_ADDR_W'(pos_y) + WRITE_ADDR_W'(row_reg);
      write_color_data  = SHIP_COLOR;
      write_transparent = is_corner(int'(col_reg), int'(row_reg), SPRITE_W, SPRITE_H);
    end
  end
endmodule

// File: doc/ship_sprite_draw.md
# ship_sprite_draw

Frame-buffer write source that draws a joystick-controlled player sprite, a solid SPRITE_W×SPRITE_H block with transparent 2×2 corners, once per frame. It moves its position on each `frame` pulse from Left/Right/Up/Down, clamped to the screen. It then streams the sprite's pixels into the frame manager over the shared write-source bus whenever the manager grants it the bus. It sits beside the background, starfield and g-sensor calibration sources as one more bus client.

## Interface
- SOURCE_ID, 3: this source's index on `write_source_sel`.
- COLOR_DEPTH, 9: pixel colour width, RGB packed MSB-first, 3 bits per channel.
- SHIP_COLOR, 9'b111111000: sprite fill colour.
- SPRITE_W, 16 / SPRITE_H, 16: sprite size in pixels; each must be at least 4.
- SCREEN_W, 640 / SCREEN_H, 480: clamp bounds.
- STEP, 4: pixels moved per frame per pressed direction.
- START_X, 312 / START_Y, 400: reset position (top-left corner).
- clk  in  1  pixel clock (clk_25 domain).
- reset  in  1  asynchronous, active-high reset.
- frame  in  1  one-cycle start-of-frame pulse.
- Left, Right, Up, Down  in  1 each  joystick levels, active-high.
- write_source_sel  in  SOURCE_SEL_ADDRW  current bus owner, driven by the manager.
- write_awaited  in  1  manager accepts the presented pixel this cycle.
- write_active  out  1  this source holds the bus and has pixels pending.
- write_x_addr, write_y_addr  out  32 each  pixel coordinates.
- write_color_data  out  COLOR_DEPTH  pixel colour.
- write_transparent  out  1  pixel must not overwrite the frame buffer.

## Operation
- Position registers `pos_x` and `pos_y` are 11 bits, unsigned.
- Position is updated only on the cycle `frame`=1:
  - Right: pos_x = min(pos_x+STEP, SCREEN_W-SPRITE_W).
  - Left: pos_x = max(pos_x-STEP, 0). No underflow wrap; saturates at 0.
  - Down and Up: same rule applied to pos_y with SCREEN_H-SPRITE_H.
  - Left and Right together: x unchanged. Up and Down together: y unchanged.
- FSM states:
  - IDLE: waits for `frame`. On `frame`, updates the position, clears col and row, and goes to WAIT_GRANT.
  - WAIT_GRANT: when `write_source_sel`==SOURCE_ID, goes to DRAW.
  - DRAW: presents the pixel at (pos_x+col, pos_y+row).
    - On `write_awaited`, advances col. On col wrap, advances row.
    - After the last pixel (col=SPRITE_W-1, row=SPRITE_H-1) is accepted, goes to DONE.
  - DONE: holds until the next `frame`, which behaves as in IDLE.
- Losing the grant in DRAW returns the FSM to WAIT_GRANT with col and row kept, so drawing resumes at the same pixel.
- `frame` in WAIT_GRANT or DRAW abandons the unfinished frame: the position updates and drawing restarts at col=row=0.
- Pixel colour is SHIP_COLOR, with `write_transparent`=1 where col∈{0,1,W-2,W-1} and row∈{0,1,H-2,H-1} simultaneously.
- Bus outputs (`write_active`, addresses, colour, transparent) are all zero unless state=DRAW and `write_source_sel`==SOURCE_ID. The manager OR-combines the sources.

## Timing
- Reset values: pos=(START_X, START_Y), state IDLE, col=row=0, every output 0.
- Outputs are combinational from registered state plus `write_source_sel`; there is no extra pipeline.
- A pixel is presented in the same cycle the grant is seen in DRAW. WAIT_GRANT→DRAW costs one cycle.
- One pixel is transferred per cycle with `write_awaited`=1. A full sprite takes SPRITE_W×SPRITE_H accepted cycles (256 by default).
- Position changes never alter a sprite already in progress, because position updates only on `frame`.
- Asynchronous reset mid-DRAW drops `write_active` immediately, without waiting for a clock edge.

## Structure
- `SOURCE_SEL_ADDRW` and the write-bus field widths come from the shared frame-manager package `frame_manager_pkg`, the same package the other sources use.
- The FSM state enum is local to this block.
- One sub-module, `sprite_pos_clamp`: position register plus saturating add/subtract for one axis, instantiated twice (x and y).

## Test plan
- Reset with defaults, then 3 `frame` pulses with no joystick input and a permanent grant → 768 accepted writes in total, the first at (312,400), the last of each frame at (327,415). Corner pixels such as (312,400) and (313,401) carry transparent=1; (314,400) carries transparent=0 with colour 9'b111111000.
- Right held for 200 frames → pos_x saturates at 624 and never exceeds it. Left held for 200 frames → pos_x=0, with no wrap to 2047.
- Grant removed after 40 accepted pixels and restored 10 cycles later → the next write is col=8, row=2, and outputs are 0 throughout the gap.
- `frame` arrives after 100 pixels with Up held → drawing restarts at row 0 with pos_y=396.
- `write_awaited` toggling 1,0,1,0 → the address advances only on the accepted cycles.
- Reset asserted mid-DRAW → `write_active`=0 within the same cycle. After release the FSM is in IDLE at (312,400).
